// File: rtl/add_8bit_signed_serial.sv
// Bit-serial signed adder: operands are captured on start, summed LSB first
// one bit per clock, and the registered sum plus signed overflow flag are
// published together with a one-cycle done pulse.
module add_8bit_signed_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    // One full-adder slice working on the current operand LSBs.
    logic s_bit, c_out, last_bit;
    assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_out    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath: capture, serial accumulate, publish on last bit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                carry_d = c_out;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // Carry into the MSB is the carry register at this step;
                    // their XOR is the signed overflow. Carry out is dropped.
                    result_d = {s_bit, sum_q[WIDTH-1:1]};
                    ovf_d    = carry_q ^ c_out;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_add_8bit_signed_serial.sv
// Randomized and directed bench for the serial signed adder; expected sums
// and overflow come from plain integer arithmetic.
module tb_add_8bit_signed_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done, overflow;
    logic [W-1:0] result;

    int n_chk  = 0;
    int n_pass = 0;

    add_8bit_signed_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    endtask

    // Reference: signed sum, wrapped result, overflow when out of range.
    function automatic logic [W-1:0] ref_sum(input int a, input int b);
        int s = a + b;
        return s[W-1:0];
    endfunction

    function automatic logic ref_ovf(input int a, input int b);
        int s = a + b;
        return (s > 127) || (s < -128);
    endfunction

    // Caller is positioned at a negedge. Launches one addition, optionally
    // pokes a stray start at busy cycle poke_at, and returns at the negedge
    // where done is seen (or the cycle bound expires).
    task automatic do_op(input int a, input int b, input int poke_at, input string tag);
        int          nbusy = 0;
        logic        changed = 1'b0;
        logic [W-1:0] r0;
        logic        o0;
        A = a[W-1:0]; B = b[W-1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = '1; B = '1;
        r0 = result; o0 = overflow;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) nbusy++;
            if (result !== r0 || overflow !== o0) changed = 1'b1;
            if (poke_at > 0 && nbusy == poke_at) begin
                start = 1'b1; A = 8'd100; B = 8'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ":busy_cycles"}, nbusy, 8);
        chk({tag, ":done"}, {31'b0, done}, 1);
        chk({tag, ":busy_in_done"}, {31'b0, busy}, 0);
        chk({tag, ":hold"}, {31'b0, changed}, 0);
        chk({tag, ":result"}, {24'b0, result}, {24'b0, ref_sum(a, b)});
        chk({tag, ":ovf"}, {31'b0, overflow}, {31'b0, ref_ovf(a, b)});
    endtask

    int corners[9] = '{0, 1, -1, 127, -128, 126, -127, 64, -64};

    initial begin
        logic saw_done;
        int   ra, rb;
        rst_n = 1'b0; start = 1'b1; A = 8'd7; B = 8'd9;
        repeat (3) @(negedge clk);
        chk("rst:busy", {31'b0, busy}, 0);
        chk("rst:done", {31'b0, done}, 0);
        chk("rst:result", {24'b0, result}, 0);
        chk("rst:ovf", {31'b0, overflow}, 0);

        // First start accepted on the very first edge with reset released.
        rst_n = 1'b1;
        do_op(127, 1, 0, "p127_1");
        @(negedge clk);
        chk("idle_after_done", {30'b0, busy, done}, 0);
        chk("hold_idle", {24'b0, result}, 8'h80);

        do_op(-128, -1, 0, "m128_m1");
        @(negedge clk);
        do_op(-1, 1, 0, "m1_p1");
        @(negedge clk);
        do_op(64, -64, 0, "p64_m64");
        @(negedge clk);

        // Stray start mid-run must be ignored.
        do_op(5, 3, 3, "ignore_start");
        @(negedge clk);

        // Back-to-back: start held in the DONE cycle.
        do_op(1, 2, 0, "b2b_first");
        A = 8'd64; B = 8'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b:done_low", {31'b0, done}, 0);
        chk("b2b:busy_high", {31'b0, busy}, 1);
        begin
            int nb = 1;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                if (busy) nb++;
            end
            chk("b2b:busy_cycles", nb, 8);
            chk("b2b:result", {24'b0, result}, {24'b0, ref_sum(64, 64)});
            chk("b2b:ovf", {31'b0, overflow}, {31'b0, ref_ovf(64, 64)});
        end
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts the operation.
        A = 8'd50; B = 8'd90; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort:busy", {31'b0, busy}, 0);
        chk("abort:result", {24'b0, result}, 0);
        chk("abort:ovf", {31'b0, overflow}, 0);
        saw_done = 1'b0;
        repeat (12) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("abort:no_done", {31'b0, saw_done}, 0);
        do_op(-1, -1, 0, "after_abort");
        @(negedge clk);

        // Corner sweep.
        foreach (corners[i]) foreach (corners[j]) begin
            do_op(corners[i], corners[j], 0, "corner");
            @(negedge clk);
        end

        // Random operands, some back-to-back without an idle cycle.
        for (int k = 0; k < 40; k++) begin
            ra = int'($urandom_range(255)) - 128;
            rb = int'($urandom_range(255)) - 128;
            do_op(ra, rb, 0, "rand");
            if ($urandom_range(1) == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
